// File: rtl/pw_pattern_match.sv
// USB byte-stream pattern matcher: masked compare of the last L bytes, arm/fill/armed/done control.
// Optional build macro PW_MATCH_COUNT_EN adds a saturating O_match_count output.
module pw_pattern_match #(
    parameter int pPATTERN_BYTES = 64,
    parameter int pCOUNT_WIDTH   = 7
) (
    input  logic                        fe_clk,
    input  logic                        reset_i,
    input  logic [7:0]                  I_data,
    input  logic                        I_data_valid,
    input  logic                        I_arm,
    input  logic                        I_disarm,
    input  logic [8*pPATTERN_BYTES-1:0] I_pattern,
    input  logic [8*pPATTERN_BYTES-1:0] I_mask,
    input  logic [pCOUNT_WIDTH-1:0]     I_pattern_bytes,
    output logic                        O_match,
    output logic                        O_armed,
    output logic [1:0]                  O_state
`ifdef PW_MATCH_COUNT_EN
    ,
    output logic [15:0]                 O_match_count
`endif
);

    // state | meaning
    // IDLE  | not armed, window still shifting
    // FILL  | armed, waiting for L bytes to enter the window
    // ARMED | window holds L fresh bytes, comparing every valid byte
    // DONE  | match reported, waiting for re-arm
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [pCOUNT_WIDTH-1:0] r_cnt;
    logic [pCOUNT_WIDTH-1:0] w_cnt_nxt;
    logic [pCOUNT_WIDTH:0]   w_cnt_inc;
    logic [pCOUNT_WIDTH-1:0] w_len;
    logic                    r_match;
    logic                    w_match_nxt;
    logic                    w_hit;
    logic [7:0]              r_window     [pPATTERN_BYTES];
    logic [7:0]              w_window_nxt [pPATTERN_BYTES];

    always_comb begin
        if (I_pattern_bytes == '0) begin
            w_len = pCOUNT_WIDTH'(1);
        end else if (int'(I_pattern_bytes) > pPATTERN_BYTES) begin
            w_len = pCOUNT_WIDTH'(pPATTERN_BYTES);
        end else begin
            w_len = I_pattern_bytes;
        end
    end

    always_comb begin
        w_window_nxt[0] = I_data_valid ? I_data : r_window[0];
        for (int k = 1; k < pPATTERN_BYTES; k++) begin
            w_window_nxt[k] = I_data_valid ? r_window[k-1] : r_window[k];
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            for (int k = 0; k < pPATTERN_BYTES; k++) begin
                r_window[k] <= '0;
            end
        end else begin
            for (int k = 0; k < pPATTERN_BYTES; k++) begin
                r_window[k] <= w_window_nxt[k];
            end
        end
    end

    // Compare against the post-shift window so the byte arriving now takes part.
    always_comb begin
        w_hit = 1'b1;
        for (int i = 0; i < pPATTERN_BYTES; i++) begin
            if ((i < int'(w_len)) &&
                (((w_window_nxt[i] ^ I_pattern[8*i +: 8]) & I_mask[8*i +: 8]) != 8'h00)) begin
                w_hit = 1'b0;
            end
        end
    end

    assign w_cnt_inc = {1'b0, r_cnt} + (pCOUNT_WIDTH+1)'(1);

    // Disarm beats arm, and arm beats any compare result.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_match_nxt = 1'b0;
        if (I_disarm) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (I_arm) begin
            w_state_nxt = S_FILL;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (I_data_valid) begin
                        if (w_cnt_inc >= {1'b0, w_len}) begin
                            w_cnt_nxt = w_len;
                            if (w_hit) begin
                                w_match_nxt = 1'b1;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_state_nxt = S_ARMED;
                            end
                        end else begin
                            w_cnt_nxt = w_cnt_inc[pCOUNT_WIDTH-1:0];
                        end
                    end else if (r_cnt >= w_len) begin
                        w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (I_data_valid && w_hit) begin
                        w_match_nxt = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_match <= w_match_nxt;
        end
    end

    assign O_match = r_match;
    assign O_state = r_state;
    assign O_armed = (r_state == S_FILL) || (r_state == S_ARMED);

`ifdef PW_MATCH_COUNT_EN
    logic [15:0] r_match_count;

    always_ff @(posedge fe_clk) begin
        if (reset_i || I_arm) begin
            r_match_count <= '0;
        end else if (w_match_nxt && (r_match_count != 16'hFFFF)) begin
            r_match_count <= r_match_count + 16'd1;
        end
    end

    assign O_match_count = r_match_count;
`endif

endmodule

// File: tb/tb_pw_pattern_match.sv
// Bench for pw_pattern_match: directed scenarios plus randomized traffic against a byte-history model.
module tb_pw_pattern_match;
    localparam int N  = 64;
    localparam int CW = 7;

    logic            fe_clk = 1'b0;
    logic            reset_i = 1'b1;
    logic [7:0]      I_data = 8'h00;
    logic            I_data_valid = 1'b0;
    logic            I_arm = 1'b0;
    logic            I_disarm = 1'b0;
    logic [8*N-1:0]  I_pattern = '0;
    logic [8*N-1:0]  I_mask = '0;
    logic [CW-1:0]   I_pattern_bytes = '0;
    logic            O_match;
    logic            O_armed;
    logic [1:0]      O_state;
`ifdef PW_MATCH_COUNT_EN
    logic [15:0]     O_match_count;
`endif

    pw_pattern_match #(.pPATTERN_BYTES(N), .pCOUNT_WIDTH(CW)) dut (
        .fe_clk          (fe_clk),
        .reset_i         (reset_i),
        .I_data          (I_data),
        .I_data_valid    (I_data_valid),
        .I_arm           (I_arm),
        .I_disarm        (I_disarm),
        .I_pattern       (I_pattern),
        .I_mask          (I_mask),
        .I_pattern_bytes (I_pattern_bytes),
        .O_match         (O_match),
        .O_armed         (O_armed),
        .O_state         (O_state)
`ifdef PW_MATCH_COUNT_EN
        ,
        .O_match_count   (O_match_count)
`endif
    );

    always #5 fe_clk = ~fe_clk;

    int checks = 0;
    int errors = 0;

    // Model: history of received bytes (index 0 newest) and a description of the arm session.
    logic [7:0] m_hist [N];
    bit         m_active;
    bit         m_fired;
    int         m_seen;
    bit         m_match;
    int         m_count;
    logic       prev_match = 1'b0;

    function automatic int eff_len();
        if (I_pattern_bytes == '0) return 1;
        if (int'(I_pattern_bytes) > N) return N;
        return int'(I_pattern_bytes);
    endfunction

    function automatic bit model_hit();
        for (int i = 0; i < eff_len(); i++) begin
            if (((m_hist[i] ^ I_pattern[8*i +: 8]) & I_mask[8*i +: 8]) != 8'h00) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [1:0] model_state();
        if (!m_active) return 2'd0;
        if (m_fired) return 2'd3;
        if (m_seen < eff_len()) return 2'd1;
        return 2'd2;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_hist[k] = 8'h00;
        m_active = 1'b0;
        m_fired  = 1'b0;
        m_seen   = 0;
        m_match  = 1'b0;
        m_count  = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit arm = 1'b0,
                        input bit disarm = 1'b0, input bit rst = 1'b0);
        logic [1:0] es;
        @(negedge fe_clk);
        I_data_valid = v;
        I_data       = d;
        I_arm        = arm;
        I_disarm     = disarm;
        reset_i      = rst;
        @(posedge fe_clk);
        #1;
        m_match = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (v) begin
                for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = d;
            end
            if (disarm) begin
                m_active = 1'b0;
            end else if (arm) begin
                m_active = 1'b1;
                m_seen   = 0;
                m_fired  = 1'b0;
            end else if (m_active && !m_fired && v) begin
                m_seen++;
                if (m_seen >= eff_len() && model_hit()) begin
                    m_fired = 1'b1;
                    m_match = 1'b1;
                end
            end
            if (arm) m_count = 0;
            else if (m_match && m_count < 65535) m_count++;
        end
        es = model_state();
        chk("match", 16'(O_match), 16'(m_match));
        chk("state", 16'(O_state), 16'(es));
        chk("armed", 16'(O_armed), 16'(es == 2'd1 || es == 2'd2));
        chk("no_double", 16'(prev_match & O_match), 16'd0);
`ifdef PW_MATCH_COUNT_EN
        chk("match_count", O_match_count, 16'(m_count));
`endif
        prev_match = O_match;
    endtask

    task automatic set_byte(input int idx, input logic [7:0] p, input logic [7:0] m);
        I_pattern[8*idx +: 8] = p;
        I_mask[8*idx +: 8]    = m;
    endtask

    initial begin
        model_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset_state", 16'(O_state), 16'd0);
        chk("reset_match", 16'(O_match), 16'd0);
        step(1'b0, 8'h00);

        // Three-byte pattern, oldest byte 0x2D
        I_pattern = '0;
        I_mask    = '1;
        set_byte(0, 8'h5A, 8'hFF);
        set_byte(1, 8'hA5, 8'hFF);
        set_byte(2, 8'h2D, 8'hFF);
        I_pattern_bytes = CW'(3);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00);
        step(1'b1, 8'h2D);
        step(1'b1, 8'hA5);
        chk("l3_before", 16'(O_match), 16'd0);
        step(1'b1, 8'h5A);
        chk("l3_match", 16'(O_match), 16'd1);
        chk("l3_done", 16'(O_state), 16'd3);
        step(1'b0, 8'h00);
        chk("l3_single", 16'(O_match), 16'd0);

        // Disarm before the completing byte
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h2D);
        step(1'b1, 8'hA5);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h5A);
        chk("disarm_nomatch", 16'(O_match), 16'd0);
        chk("disarm_idle", 16'(O_state), 16'd0);

        // Masked low nibble
        I_pattern = '0;
        I_mask    = '0;
        set_byte(0, 8'h30, 8'hF0);
        set_byte(1, 8'h12, 8'hFF);
        I_pattern_bytes = CW'(2);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h12);
        step(1'b1, 8'h3F);
        chk("nibble_match", 16'(O_match), 16'd1);

        // Zero length clamps to one byte, FILL straight to DONE
        I_pattern = '0;
        I_mask    = '0;
        set_byte(0, 8'h80, 8'hFF);
        I_pattern_bytes = '0;
        step(1'b0, 8'h00, 1'b1);
        chk("len0_fill", 16'(O_state), 16'd1);
        step(1'b1, 8'h80);
        chk("len0_match", 16'(O_match), 16'd1);
        chk("len0_done", 16'(O_state), 16'd3);

        // No second pulse without re-arm; re-arm clears the count
        step(1'b1, 8'h80);
        chk("noarm_nomatch", 16'(O_match), 16'd0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h80);
        chk("rearm_match", 16'(O_match), 16'd1);
`ifdef PW_MATCH_COUNT_EN
        chk("rearm_count", O_match_count, 16'd1);
`endif

        // Reset on a hitting byte
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
        chk("rst_nomatch", 16'(O_match), 16'd0);
        chk("rst_idle", 16'(O_state), 16'd0);
        step(1'b0, 8'h00);
        chk("rst_after", 16'(O_match), 16'd0);

        // Arm beats a hitting byte in ARMED; disarm beats arm
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00);
        chk("armed_state", 16'(O_state), 16'd2);
        step(1'b1, 8'h80, 1'b1);
        chk("armwins_nomatch", 16'(O_match), 16'd0);
        chk("armwins_fill", 16'(O_state), 16'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("disarmwins", 16'(O_state), 16'd0);

        // Oversized length clamps to the full window
        I_pattern = '0;
        I_mask    = '0;
        set_byte(0, 8'h11, 8'hFF);
        set_byte(1, 8'h22, 8'hFF);
        I_pattern_bytes = CW'(100);
        step(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 62; k++) step(1'b1, 8'h00);
        step(1'b1, 8'h22);
        chk("clamp_fill", 16'(O_state), 16'd1);
        step(1'b1, 8'h11);
        chk("clamp_match", 16'(O_match), 16'd1);

        // Randomized segments with small alphabet so hits are common
        for (int seg = 0; seg < 20; seg++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            I_pattern = '0;
            I_mask    = '0;
            for (int b = 0; b < N; b++) begin
                logic [7:0] mk;
                case ($urandom_range(0, 3))
                    0: mk = 8'hF0;
                    1: mk = 8'h0F;
                    2: mk = 8'($urandom);
                    default: mk = 8'hFF;
                endcase
                set_byte(b, 8'($urandom_range(0, 3)), mk);
            end
            I_pattern_bytes = CW'($urandom_range(0, 4));
            step(1'b0, 8'h00, 1'b1);
            for (int c = 0; c < 150; c++) begin
                step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3)),
                     ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0),
                     ($urandom_range(0, 299) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
